sal_timing_cfg: RTL and testbench
=================================

# sal_timing_cfg

APB-programmable DRAM timing configuration block; successor to the fixed-constant timing source. Holds one shared shadow timing set written over APB and an independent active timing set per channel (NUM_CH), driving the per-channel scheduler and timing checkers. Shadow-to-active commit is requested by software and applied per channel only while that channel reports idle, so timing never changes under an open bank or an in-flight burst.

## Interface
Parameters:
- NUM_CH, 2: number of DRAM channels, 1..4.
- DEF_TIMING0, 32'h0E_13_05_05: reset value of TIMING0 (shadow and all active sets).
- DEF_TIMING1, 32'h05_03_03_03: reset value of TIMING1.
- DEF_TIMING2, 32'h08_04_00_2F: reset value of TIMING2.
- DEF_TIMING3, 32'h06_04_02_10: reset value of TIMING3.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  12  APB byte address.
- pwdata  in  32  APB write data.
- pready  out  1  tied 1 (zero wait states).
- prdata  out  32  registered read data.
- pslverr  out  1  APB error, valid in access phase.
- ch_idle  in  NUM_CH  per-channel "no open row, no pending burst".
- t_rcd_m1, t_rp_m1, t_ras_m1, t_rc_m1  out  NUM_CH*8 each  active TIMING0 fields, channel c at [8c+:8].
- t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  out  NUM_CH*8 each  active TIMING1 fields.
- t_rfc_m1  out  NUM_CH*16; t_rtp_m1, t_wtp_m1  out  NUM_CH*8 each  active TIMING2 fields.
- row_open_cnt  out  NUM_CH*8; burst_cycle_m2, dfi_wren_lat, dfi_rden_lat  out  NUM_CH*4 each  active TIMING3 fields.
- t_rcd_m2, t_rp_m2  out  NUM_CH*8; t_rfc_m2  out  NUM_CH*16  derived per channel.
- cfg_pending  out  NUM_CH  commit outstanding per channel.

## Operation
- Register map (word-aligned): 0x000 ID RO = 32'h5341_4C02; 0x004 CTRL: bit0 UPDATE_REQ (W1, reads 0), bit1 LOCK (write-1-sticky until rst), bits[8+:NUM_CH] channel mask; 0x008 STATUS RO: bits[0+:NUM_CH] = cfg_pending; 0x010 TIMING0 = {t_ras,t_rc... }: [7:0] rcd, [15:8] rp, [23:16] ras, [31:24] rc; 0x014 TIMING1: [7:0] rrd, [15:8] ccd, [23:16] wtr, [31:24] rtw; 0x018 TIMING2: [15:0] rfc, [23:16] rtp, [31:24] wtp; 0x01C TIMING3: [7:0] row_open_cnt, [11:8] burst_cycle_m2, [19:16] wren_lat, [27:24] rden_lat, other bits RAZ/WI.
- Timing register reads return shadow, not active.
- Writing CTRL with bit0=1 sets cfg_pending[c] for each mask bit c; mask bits are stored and readable. Mask 0: no-op, no error.
- Per channel, each cycle: if cfg_pending[c] && ch_idle[c], copy all four shadow words into active set c, clear cfg_pending[c]. Channels commit independently.
- Derived: x_m2 = (x_m1 == 0) ? 0 : x_m1 - 1 (saturating), from active set.
- pslverr=1, no state change: paddr[1:0]≠0; unmapped address (read or write; prdata=0); write to ID/STATUS; write to TIMING0-3 while any cfg_pending bit set; any write to CTRL or TIMING0-3 while LOCK=1 (LOCK itself stays 1).
- Reset: shadow and all active sets = DEF_TIMING0..3; cfg_pending=0, mask=0, LOCK=0, prdata=0, pslverr=0. Reset mid-commit discards pending; active returns to defaults.

## Timing
- APB setup (psel && !penable): prdata and pslverr registered at that edge; valid throughout access phase.
- Write effect at access-phase edge (psel && penable && pwrite); shadow/CTRL/pending visible the next cycle.
- Commit: edge where pending && ch_idle both 1 updates active; outputs change 1 cycle after. UPDATE_REQ write and ch_idle=1 in same cycle: pending set at that edge, commit at earliest following edge (minimum 2-cycle write-to-output latency).
- ch_idle dropping before commit: pending held, commit waits.
- Derived m2 outputs are combinational from active registers (same cycle as m1).

## Test plan
- Reset -> all channels t_rcd_m1=5, t_rc_m1=0x0E, t_rfc_m1=0x2F, t_rfc_m2=0x2E, ID read = 32'h5341_4C02, pslverr=0.
- Write TIMING0=32'h10_18_06_07, CTRL=0x301 (mask ch0,ch1), ch_idle=2'b01 -> ch0 t_rcd_m1=7 two cycles after write, ch1 unchanged and cfg_pending=2'b10 until ch_idle[1]=1, then ch1 t_rcd_m1=7 next cycle.
- Write TIMING1 while cfg_pending≠0 -> pslverr=1, shadow readback unchanged.
- Write TIMING0 with rcd=0, commit -> t_rcd_m1=0, t_rcd_m2=0 (saturation).
- Write CTRL=0x2 (LOCK), then TIMING2 write -> pslverr=1; read paddr 0x020 -> pslverr=1, prdata=0; read 0x011 -> pslverr=1.
- Assert rst while cfg_pending=2'b11 -> pending cleared, outputs back to DEF values, LOCK=0.

Source files
------------

// File: rtl/sal_timing_cfg.sv
// APB-programmable DRAM timing: shared shadow set, per-channel active sets committed only while the channel is idle.
// APB zero-wait (pready=1); read data/err registered at setup; commit lands one edge after pending && ch_idle.
module sal_timing_cfg #(
  parameter int          NUM_CH      = 2,
  parameter logic [31:0] DEF_TIMING0 = 32'h0E_13_05_05,
  parameter logic [31:0] DEF_TIMING1 = 32'h05_03_03_03,
  parameter logic [31:0] DEF_TIMING2 = 32'h08_04_00_2F,
  parameter logic [31:0] DEF_TIMING3 = 32'h06_04_02_10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [11:0]           paddr,
  input  logic [31:0]           pwdata,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  input  logic [NUM_CH-1:0]     ch_idle,
  output logic [NUM_CH*8-1:0]   t_rcd_m1,
  output logic [NUM_CH*8-1:0]   t_rp_m1,
  output logic [NUM_CH*8-1:0]   t_ras_m1,
  output logic [NUM_CH*8-1:0]   t_rc_m1,
  output logic [NUM_CH*8-1:0]   t_rrd_m1,
  output logic [NUM_CH*8-1:0]   t_ccd_m1,
  output logic [NUM_CH*8-1:0]   t_wtr_m1,
  output logic [NUM_CH*8-1:0]   t_rtw_m1,
  output logic [NUM_CH*16-1:0]  t_rfc_m1,
  output logic [NUM_CH*8-1:0]   t_rtp_m1,
  output logic [NUM_CH*8-1:0]   t_wtp_m1,
  output logic [NUM_CH*8-1:0]   row_open_cnt,
  output logic [NUM_CH*4-1:0]   burst_cycle_m2,
  output logic [NUM_CH*4-1:0]   dfi_wren_lat,
  output logic [NUM_CH*4-1:0]   dfi_rden_lat,
  output logic [NUM_CH*8-1:0]   t_rcd_m2,
  output logic [NUM_CH*8-1:0]   t_rp_m2,
  output logic [NUM_CH*16-1:0]  t_rfc_m2,
  output logic [NUM_CH-1:0]     cfg_pending
);

  localparam logic [31:0] ID_VAL     = 32'h5341_4C02;
  localparam logic [31:0] T3_WR_MASK = 32'h0F0F_0FFF;

  logic [3:0][31:0]   shadow;
  logic [3:0][31:0]   act [NUM_CH];
  logic [NUM_CH-1:0]  mask;
  logic               lock;
  logic [NUM_CH-1:0]  pending;

  logic [31:0]        rd_val;
  logic               addr_ok;
  logic               wr_bad;
  logic               acc_err;
  logic               wr_acc;
  logic [NUM_CH-1:0]  commit;
  logic [NUM_CH-1:0]  pend_set;

  assign pready      = 1'b1;
  assign cfg_pending = pending;

  always_comb begin
    rd_val  = '0;
    addr_ok = 1'b1;
    wr_bad  = 1'b0;
    case (paddr)
      12'h000: begin
        rd_val = ID_VAL;
        wr_bad = 1'b1;
      end
      12'h004: begin
        rd_val[1]           = lock;
        rd_val[8 +: NUM_CH] = mask;
        wr_bad              = lock;
      end
      12'h008: begin
        rd_val[NUM_CH-1:0] = pending;
        wr_bad             = 1'b1;
      end
      12'h010, 12'h014, 12'h018, 12'h01C: begin
        rd_val = shadow[paddr[3:2]];
        // Shadow is frozen while any channel still has to copy it.
        wr_bad = lock || (|pending);
      end
      default: addr_ok = 1'b0;
    endcase
    acc_err = !addr_ok || (pwrite && wr_bad);
  end

  // The error decided at setup also gates the access-phase write.
  assign wr_acc = psel && penable && pwrite && !pslverr;

  always_comb begin
    commit   = pending & ch_idle;
    pend_set = '0;
    if (wr_acc && paddr == 12'h004 && pwdata[0])
      pend_set = pwdata[8 +: NUM_CH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= {DEF_TIMING3, DEF_TIMING2, DEF_TIMING1, DEF_TIMING0};
      for (int c = 0; c < NUM_CH; c++)
        act[c] <= {DEF_TIMING3, DEF_TIMING2, DEF_TIMING1, DEF_TIMING0};
      mask    <= '0;
      lock    <= 1'b0;
      pending <= '0;
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (commit[c])
          act[c] <= shadow;
      pending <= (pending & ~commit) | pend_set;

      if (psel && !penable) begin
        prdata  <= pwrite ? 32'h0 : rd_val;
        pslverr <= acc_err;
      end

      if (wr_acc) begin
        case (paddr)
          12'h004: begin
            lock <= lock | pwdata[1];
            mask <= pwdata[8 +: NUM_CH];
          end
          12'h010, 12'h014, 12'h018: shadow[paddr[3:2]] <= pwdata;
          12'h01C: shadow[3] <= pwdata & T3_WR_MASK;
          default: ;
        endcase
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign t_rcd_m1[8*c +: 8]        = act[c][0][7:0];
    assign t_rp_m1[8*c +: 8]         = act[c][0][15:8];
    assign t_ras_m1[8*c +: 8]        = act[c][0][23:16];
    assign t_rc_m1[8*c +: 8]         = act[c][0][31:24];
    assign t_rrd_m1[8*c +: 8]        = act[c][1][7:0];
    assign t_ccd_m1[8*c +: 8]        = act[c][1][15:8];
    assign t_wtr_m1[8*c +: 8]        = act[c][1][23:16];
    assign t_rtw_m1[8*c +: 8]        = act[c][1][31:24];
    assign t_rfc_m1[16*c +: 16]      = act[c][2][15:0];
    assign t_rtp_m1[8*c +: 8]        = act[c][2][23:16];
    assign t_wtp_m1[8*c +: 8]        = act[c][2][31:24];
    assign row_open_cnt[8*c +: 8]    = act[c][3][7:0];
    assign burst_cycle_m2[4*c +: 4]  = act[c][3][11:8];
    assign dfi_wren_lat[4*c +: 4]    = act[c][3][19:16];
    assign dfi_rden_lat[4*c +: 4]    = act[c][3][27:24];

    // Saturating decrement so a zero timing never wraps to max.
    assign t_rcd_m2[8*c +: 8]   = (act[c][0][7:0]  == 8'd0)  ? 8'd0  : act[c][0][7:0]  - 8'd1;
    assign t_rp_m2[8*c +: 8]    = (act[c][0][15:8] == 8'd0)  ? 8'd0  : act[c][0][15:8] - 8'd1;
    assign t_rfc_m2[16*c +: 16] = (act[c][2][15:0] == 16'd0) ? 16'd0 : act[c][2][15:0] - 16'd1;

    logic unused_t3_bits;
    assign unused_t3_bits = ^{act[c][3][31:28], act[c][3][23:20], act[c][3][15:12]};
  end

endmodule

// File: tb/tb_sal_timing_cfg.sv
module tb_sal_timing_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [1:0]  ch_idle;
  logic [15:0] t_rcd_m1, t_rp_m1, t_ras_m1, t_rc_m1;
  logic [15:0] t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
  logic [31:0] t_rfc_m1;
  logic [15:0] t_rtp_m1, t_wtp_m1, row_open_cnt;
  logic [7:0]  burst_cycle_m2, dfi_wren_lat, dfi_rden_lat;
  logic [15:0] t_rcd_m2, t_rp_m2;
  logic [31:0] t_rfc_m2;
  logic [1:0]  cfg_pending;

  int errors = 0;
  int checks = 0;

  sal_timing_cfg #(.NUM_CH(2)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .ch_idle(ch_idle),
    .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1), .t_rc_m1(t_rc_m1),
    .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
    .t_rfc_m1(t_rfc_m1), .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1),
    .row_open_cnt(row_open_cnt), .burst_cycle_m2(burst_cycle_m2),
    .dfi_wren_lat(dfi_wren_lat), .dfi_rden_lat(dfi_rden_lat),
    .t_rcd_m2(t_rcd_m2), .t_rp_m2(t_rp_m2), .t_rfc_m2(t_rfc_m2),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    d = prdata;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    checks++; if (t_rcd_m1 !== 16'h0505) begin errors++; $display("FAIL reset_rcd: got %h want 0505", t_rcd_m1); end
    checks++; if (t_rc_m1 !== 16'h0E0E) begin errors++; $display("FAIL reset_rc: got %h want 0e0e", t_rc_m1); end
    checks++; if (t_rfc_m1 !== 32'h002F_002F) begin errors++; $display("FAIL reset_rfc: got %h want 002f002f", t_rfc_m1); end
    checks++; if (t_rfc_m2 !== 32'h002E_002E) begin errors++; $display("FAIL reset_rfc_m2: got %h want 002e002e", t_rfc_m2); end
    checks++; if (row_open_cnt !== 16'h1010 || dfi_rden_lat !== 8'h66) begin errors++; $display("FAIL reset_t3: got %h/%h want 1010/66", row_open_cnt, dfi_rden_lat); end
    checks++; if (pslverr !== 1'b0 || prdata !== 32'h0 || cfg_pending !== 2'b00) begin errors++; $display("FAIL reset_regs: got err=%b rd=%h pend=%b want 0/0/0", pslverr, prdata, cfg_pending); end
    checks++; if (pready !== 1'b1) begin errors++; $display("FAIL pready: got %b want 1", pready); end
    apb_read(12'h000, d, e);
    checks++; if (d !== 32'h5341_4C02 || e !== 1'b0) begin errors++; $display("FAIL id_read: got %h err=%b want 53414c02 err=0", d, e); end
  endtask

  task automatic test_commit();
    logic e;
    ch_idle = 2'b01;
    apb_write(12'h010, 32'h10_18_06_07, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL t0_write_err: got %b want 0", e); end
    apb_write(12'h004, 32'h0000_0301, e);
    checks++; if (cfg_pending !== 2'b11 || t_rcd_m1[7:0] !== 8'h05) begin errors++; $display("FAIL commit_t1: got pend=%b rcd0=%h want 11/05", cfg_pending, t_rcd_m1[7:0]); end
    @(posedge clk); #1;
    checks++; if (t_rcd_m1 !== 16'h0507 || t_rc_m1[7:0] !== 8'h10 || t_ras_m1[7:0] !== 8'h18) begin errors++; $display("FAIL commit_ch0: got rcd=%h rc0=%h ras0=%h want 0507/10/18", t_rcd_m1, t_rc_m1[7:0], t_ras_m1[7:0]); end
    checks++; if (t_rcd_m2[7:0] !== 8'h06 || cfg_pending !== 2'b10) begin errors++; $display("FAIL commit_ch0_m2: got m2=%h pend=%b want 06/10", t_rcd_m2[7:0], cfg_pending); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cfg_pending !== 2'b10 || t_rcd_m1[15:8] !== 8'h05) begin errors++; $display("FAIL ch1_hold: got pend=%b rcd1=%h want 10/05", cfg_pending, t_rcd_m1[15:8]); end
  endtask

  task automatic test_pending_block();
    logic [31:0] d;
    logic        e;
    apb_write(12'h014, 32'h1122_3344, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL t1_blocked: got err=%b want 1", e); end
    apb_read(12'h014, d, e);
    checks++; if (d !== 32'h0503_0303 || e !== 1'b0) begin errors++; $display("FAIL t1_readback: got %h err=%b want 05030303 err=0", d, e); end
    apb_read(12'h010, d, e);
    checks++; if (d !== 32'h1018_0607) begin errors++; $display("FAIL t0_shadow: got %h want 10180607", d); end
    apb_read(12'h008, d, e);
    checks++; if (d !== 32'h2 || e !== 1'b0) begin errors++; $display("FAIL status: got %h err=%b want 2 err=0", d, e); end
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h300) begin errors++; $display("FAIL ctrl_read: got %h want 300", d); end
    ch_idle = 2'b11;
    @(posedge clk); #1;
    checks++; if (t_rcd_m1 !== 16'h0707 || t_rp_m1[15:8] !== 8'h06 || cfg_pending !== 2'b00) begin errors++; $display("FAIL commit_ch1: got rcd=%h rp1=%h pend=%b want 0707/06/00", t_rcd_m1, t_rp_m1[15:8], cfg_pending); end
  endtask

  task automatic test_saturation();
    logic e;
    apb_write(12'h010, 32'h10_18_06_00, e);
    apb_write(12'h004, 32'h0000_0101, e);
    @(posedge clk); #1;
    checks++; if (t_rcd_m1 !== 16'h0700 || t_rcd_m2[7:0] !== 8'h00) begin errors++; $display("FAIL sat: got rcd=%h m2=%h want 0700/00", t_rcd_m1, t_rcd_m2[7:0]); end
    checks++; if (t_rp_m2 !== 16'h0505 || t_rcd_m2[15:8] !== 8'h06) begin errors++; $display("FAIL sat_other: got rp_m2=%h rcd_m2_1=%h want 0505/06", t_rp_m2, t_rcd_m2[15:8]); end
  endtask

  task automatic test_reset_mid_commit();
    logic [31:0] d;
    logic        e;
    ch_idle = 2'b00;
    apb_write(12'h010, 32'h0102_0304, e);
    apb_write(12'h004, 32'h0000_0303, e);
    checks++; if (cfg_pending !== 2'b11) begin errors++; $display("FAIL mid_pend: got %b want 11", cfg_pending); end
    pulse_rst();
    ch_idle = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cfg_pending !== 2'b00 || t_rcd_m1 !== 16'h0505 || t_rc_m1 !== 16'h0E0E) begin errors++; $display("FAIL mid_rst: got pend=%b rcd=%h rc=%h want 00/0505/0e0e", cfg_pending, t_rcd_m1, t_rc_m1); end
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_ctrl: got %h want 0", d); end
    apb_read(12'h010, d, e);
    checks++; if (d !== 32'h0E13_0505) begin errors++; $display("FAIL mid_shadow: got %h want 0e130505", d); end
  endtask

  task automatic test_lock_and_errors();
    logic [31:0] d;
    logic        e;
    apb_write(12'h01C, 32'hFFFF_FFFF, e);
    apb_read(12'h01C, d, e);
    checks++; if (d !== 32'h0F0F_0FFF) begin errors++; $display("FAIL t3_raz: got %h want 0f0f0fff", d); end
    apb_write(12'h000, 32'h1234_5678, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL id_write: got err=%b want 1", e); end
    apb_write(12'h004, 32'h0000_0002, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lock_set: got err=%b want 0", e); end
    apb_write(12'h018, 32'h1111_2222, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL lock_t2: got err=%b want 1", e); end
    apb_read(12'h018, d, e);
    checks++; if (d !== 32'h0804_002F) begin errors++; $display("FAIL lock_t2_rb: got %h want 0804002f", d); end
    apb_write(12'h004, 32'h0000_0301, e);
    checks++; if (e !== 1'b1 || cfg_pending !== 2'b00) begin errors++; $display("FAIL lock_ctrl: got err=%b pend=%b want 1/00", e, cfg_pending); end
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL lock_sticky: got %h want 2", d); end
    apb_read(12'h020, d, e);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped: got err=%b rd=%h want 1/0", e, d); end
    apb_read(12'h011, d, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned: got err=%b want 1", e); end
    pulse_rst();
    apb_write(12'h014, 32'h0A0B_0C0D, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL unlock_rst: got err=%b want 0", e); end
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; ch_idle = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_commit();
    test_pending_block();
    test_saturation();
    test_reset_mid_commit();
    test_lock_and_errors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
